// File: rtl/cmp_minmax_sched_pkg.sv
// Shared definitions for the min/max sequencing controller: state encoding
// and its width.
package cmp_minmax_sched_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CMP_MIN = 3'd2,
        ST_CMP_MAX = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/CmpZelg.sv
// Purely combinational unsigned magnitude comparator shared by the min and
// max passes.
module CmpZelg #(
    parameter int unsigned p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] iv_x,
    input  logic [p_WIDTH-1:0] iv_y,
    output logic               o_zero,
    output logic               o_equal,
    output logic               o_less,
    output logic               o_greater
);

    always_comb begin
        o_zero    = (iv_x == '0);
        o_equal   = (iv_x == iv_y);
        o_less    = (iv_x < iv_y);
        o_greater = (iv_x > iv_y);
    end

endmodule

// File: rtl/cmp_minmax_sched.sv
// Streams a run of unsigned samples and tracks min/max with first-occurrence
// indices, time-sharing one comparator between a min pass and a max pass.
module cmp_minmax_sched
    import cmp_minmax_sched_pkg::*;
#(
    parameter int unsigned p_WIDTH     = 8,
    parameter int unsigned p_CNT_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [p_CNT_WIDTH-1:0] iv_len,
    input  logic                   i_valid,
    input  logic [p_WIDTH-1:0]     iv_data,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [p_WIDTH-1:0]     ov_min,
    output logic [p_WIDTH-1:0]     ov_max,
    output logic [p_CNT_WIDTH-1:0] ov_min_idx,
    output logic [p_CNT_WIDTH-1:0] ov_max_idx
);

    state_e                 state_q, state_d;
    logic [p_CNT_WIDTH-1:0] len_q, len_d;
    logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [p_WIDTH-1:0]     sample_q, sample_d;
    logic [p_WIDTH-1:0]     min_q, min_d;
    logic [p_WIDTH-1:0]     max_q, max_d;
    logic [p_CNT_WIDTH-1:0] min_idx_q, min_idx_d;
    logic [p_CNT_WIDTH-1:0] max_idx_q, max_idx_d;
    logic                   ready_q, busy_q, done_q;

    logic [p_WIDTH-1:0]     cmp_y_c;
    logic                   cmp_less_c, cmp_greater_c;
    logic [p_CNT_WIDTH-1:0] cnt_inc_c;

    // Only the max pass compares against the running maximum.
    assign cmp_y_c   = (state_q == ST_CMP_MAX) ? max_q : min_q;
    assign cnt_inc_c = cnt_q + p_CNT_WIDTH'(1);

    CmpZelg #(
        .p_WIDTH (p_WIDTH)
    ) u_cmp (
        .iv_x      (sample_q),
        .iv_y      (cmp_y_c),
        .o_zero    (),
        .o_equal   (),
        .o_less    (cmp_less_c),
        .o_greater (cmp_greater_c)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d     = iv_len;
                    cnt_d     = '0;
                    min_d     = '0;
                    max_d     = '0;
                    min_idx_d = '0;
                    max_idx_d = '0;
                    state_d   = (iv_len != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (i_valid) begin
                    sample_d = iv_data;
                    if (cnt_q == '0) begin
                        // First sample seeds both extremes without a compare.
                        min_d     = iv_data;
                        max_d     = iv_data;
                        min_idx_d = '0;
                        max_idx_d = '0;
                        cnt_d     = p_CNT_WIDTH'(1);
                        state_d   = (len_q == p_CNT_WIDTH'(1)) ? ST_DONE : ST_FETCH;
                    end else begin
                        state_d = ST_CMP_MIN;
                    end
                end
            end
            ST_CMP_MIN: begin
                if (cmp_less_c) begin
                    min_d     = sample_q;
                    min_idx_d = cnt_q;
                end
                state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                if (cmp_greater_c) begin
                    max_d     = sample_q;
                    max_idx_d = cnt_q;
                end
                cnt_d   = cnt_inc_c;
                state_d = (cnt_inc_c == len_q) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            ready_q   <= (state_d == ST_FETCH);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign ov_min     = min_q;
    assign ov_max     = max_q;
    assign ov_min_idx = min_idx_q;
    assign ov_max_idx = max_idx_q;

endmodule

// File: tb/tb_cmp_minmax_sched.sv
// Directed bench for cmp_minmax_sched: hand-computed min/max results, indices
// and cycle timing for several runs.
module tb_cmp_minmax_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       valid;
    logic [7:0] data;
    logic       ready, busy, done;
    logic [7:0] vmin, vmax;
    logic [3:0] min_idx, max_idx;

    int checks = 0;
    int errors = 0;

    int data_mem [16];
    int xfer_at  [16];
    int n_xfer, done_at, done_cnt, ready_seen;
    int r_min, r_max, r_min_idx, r_max_idx;

    cmp_minmax_sched #(
        .p_WIDTH     (8),
        .p_CNT_WIDTH (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .iv_len     (len),
        .i_valid    (valid),
        .iv_data    (data),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_done     (done),
        .ov_min     (vmin),
        .ov_max     (vmax),
        .ov_min_idx (min_idx),
        .ov_max_idx (max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // mode 0: valid held high; 1: valid random; 2: valid high and start held mid-run
    task automatic run(input int run_len, input int mode);
        int k;
        logic v;
        n_xfer = 0; done_at = -1; done_cnt = 0; ready_seen = 0;
        @(negedge clk);
        start = 1'b1;
        len   = 4'(run_len);
        valid = 1'b0;
        for (k = 1; k < 300; k++) begin
            @(negedge clk);
            start = (mode == 2) && (done_cnt == 0);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at   = k;
                    r_min     = int'(vmin);
                    r_max     = int'(vmax);
                    r_min_idx = int'(min_idx);
                    r_max_idx = int'(max_idx);
                end
            end
            if (ready) ready_seen = 1;
            v = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            valid = v;
            data  = (n_xfer < 16) ? 8'(data_mem[n_xfer]) : 8'h00;
            if (ready && v) begin
                if (n_xfer < 16) xfer_at[n_xfer] = k;
                n_xfer++;
            end
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        start = 1'b0;
        valid = 1'b0;
        if (done_at < 0) chk("run_timeout", 0, 1);
    endtask

    task automatic chk_result(input string tag, input int mn, input int mni,
                              input int mx, input int mxi);
        chk({tag, "_min"},     r_min,     mn);
        chk({tag, "_min_idx"}, r_min_idx, mni);
        chk({tag, "_max"},     r_max,     mx);
        chk({tag, "_max_idx"}, r_max_idx, mxi);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_min",   int'(vmin),  0);
        chk("rst_max",   int'(vmax),  0);
        chk("rst_idx",   int'({min_idx, max_idx}), 0);
        rst = 1'b0;

        // Reset in the middle of a len=5 run after two transfers
        @(negedge clk); start = 1'b1; len = 4'd5;
        @(negedge clk); start = 1'b0; valid = 1'b1; data = 8'd10;
        @(negedge clk); data = 8'd20;
        @(negedge clk); valid = 1'b0;
        chk("mid_busy_pre", int'(busy), 1);
        chk("mid_min_pre",  int'(vmin), 10);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_busy",  int'(busy),  0);
        chk("mid_rst_ready", int'(ready), 0);
        chk("mid_rst_res",   int'({vmin, vmax, min_idx, max_idx}), 0);

        data_mem[0] = 8'h2A;
        run(1, 0);
        chk_result("len1", 42, 0, 42, 0);
        chk("len1_lat", done_at - xfer_at[0], 1);

        // Basic run 7,3,9,3
        data_mem[0] = 7; data_mem[1] = 3; data_mem[2] = 9; data_mem[3] = 3;
        run(4, 0);
        chk_result("basic", 3, 1, 9, 2);
        chk("basic_xfers",  n_xfer, 4);
        chk("basic_gap1",   xfer_at[1] - xfer_at[0], 1);
        chk("basic_gap2",   xfer_at[2] - xfer_at[1], 3);
        chk("basic_gap3",   xfer_at[3] - xfer_at[2], 3);
        chk("basic_lat",    done_at - xfer_at[3], 3);
        @(negedge clk);
        chk("basic_hold_min", int'(vmin), 3);
        chk("basic_hold_busy", int'(busy), 0);

        // Random backpressure, same data
        run(4, 1);
        chk_result("bp", 3, 1, 9, 2);

        // Start held during the run must be ignored
        run(4, 2);
        chk_result("start_mid", 3, 1, 9, 2);
        chk("start_mid_xfers", n_xfer, 4);

        // Boundary values
        data_mem[0] = 8'h00; data_mem[1] = 8'hFF; data_mem[2] = 8'h00;
        run(3, 0);
        chk_result("bound", 0, 0, 255, 1);

        data_mem[0] = 5; data_mem[1] = 5; data_mem[2] = 5;
        run(3, 0);
        chk_result("equal", 5, 0, 5, 0);

        // Zero length
        run(0, 0);
        chk_result("zero", 0, 0, 0, 0);
        chk("zero_lat",   done_at, 1);
        chk("zero_ready", ready_seen, 0);
        chk("zero_xfers", n_xfer, 0);

        // Full-length run: 15,14,...,2 then 0 at index 14
        for (int i = 0; i < 15; i++) data_mem[i] = 15 - i;
        data_mem[14] = 0;
        run(15, 0);
        chk_result("full", 0, 14, 15, 0);
        chk("full_xfers", n_xfer, 15);
        chk("full_lat",   done_at - xfer_at[14], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
